// File: rtl/mac_pkg.sv
// Shared widths, FSM state type and accumulate helper for mac_job_scheduler.
// Defining MAC_SAT_EN makes acc_add saturate; otherwise it wraps.
package mac_pkg;

   localparam int PIXEL_WIDTH  = 10;
   localparam int WEIGHT_WIDTH = 19;
   localparam int OUTPUT_WIDTH = 26;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      RESULT
   } state_t;

   localparam logic [OUTPUT_WIDTH-1:0] SAT_MAX =
      {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
   localparam logic [OUTPUT_WIDTH-1:0] SAT_MIN =
      {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

   function automatic logic [OUTPUT_WIDTH-1:0] acc_add(
      input logic [OUTPUT_WIDTH-1:0] a,
      input logic [OUTPUT_WIDTH-1:0] b
   );
      logic [OUTPUT_WIDTH-1:0] s;
      s = a + b;
`ifdef MAC_SAT_EN
      // Same-sign operands producing an opposite-sign sum overflowed.
      if ((a[OUTPUT_WIDTH-1] == b[OUTPUT_WIDTH-1]) &&
          (s[OUTPUT_WIDTH-1] != a[OUTPUT_WIDTH-1]))
         s = a[OUTPUT_WIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
      return s;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts one past the last grant.
// The pointer moves only on advance, i.e. when the grant is actually taken.
module rr_arbiter
   import mac_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_next;
   logic [PW:0]   w_idx;
   logic          w_found;

   always_comb begin
      grant   = '0;
      w_next  = r_ptr;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < N; i++) begin
         w_idx = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_idx >= (PW+1)'(N))
            w_idx = w_idx - (PW+1)'(N);
         if (!w_found && req[w_idx[PW-1:0]]) begin
            w_found                = 1'b1;
            grant[w_idx[PW-1:0]]   = 1'b1;
            w_next = (w_idx[PW-1:0] == PW'(N-1)) ?
                     '0 : w_idx[PW-1:0] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_ptr <= '0;
      else if (advance && w_found)
         r_ptr <= w_next;
   end

endmodule

// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler: grants jobs round-robin, streams pairs into a shared
// pipelined multiplier and accumulates products. MAC_SAT_EN: saturate.
module mac_job_scheduler
   import mac_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int NUM_INPUTS   = 4,
   parameter int MULT_LATENCY = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*NUM_INPUTS*PIXEL_WIDTH-1:0]  req_pixels,
   input  logic [NUM_REQ*NUM_INPUTS*WEIGHT_WIDTH-1:0] req_weights,
   output logic [PIXEL_WIDTH-1:0]    mult_pixel,
   output logic [WEIGHT_WIDTH-1:0]   mult_weight,
   input  logic [OUTPUT_WIDTH-1:0]   mult_product,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [$clog2(NUM_REQ)-1:0] res_id,
   output logic [OUTPUT_WIDTH-1:0]   res_data,
   output logic                      busy
);

   localparam int IDW     = $clog2(NUM_REQ);
   localparam int CNT_MAX = (NUM_INPUTS > MULT_LATENCY) ?
                            NUM_INPUTS : MULT_LATENCY;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int KW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CW-1:0]             r_cnt;
   logic [CW-1:0]             w_cnt_nxt;
   logic [KW-1:0]             w_k;
   logic [MULT_LATENCY-1:0]   r_vpipe;
   logic [MULT_LATENCY-1:0]   w_vpipe_nxt;
   logic [OUTPUT_WIDTH-1:0]   r_acc;
   logic [IDW-1:0]            r_id;
   logic [IDW-1:0]            w_gid;
   logic [NUM_REQ-1:0]        w_grant;
   logic                      w_take;
   logic                      w_issue;

   logic [PIXEL_WIDTH-1:0]    r_pix [NUM_INPUTS];
   logic [WEIGHT_WIDTH-1:0]   r_wgt [NUM_INPUTS];
   logic [PIXEL_WIDTH-1:0]    w_cap_pix [NUM_INPUTS];
   logic [WEIGHT_WIDTH-1:0]   w_cap_wgt [NUM_INPUTS];

   rr_arbiter #(
      .N       (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (w_take),
      .grant   (w_grant)
   );

   assign w_take    = (r_state == IDLE) && rst && (|req_valid);
   assign req_ready = w_take ? w_grant : '0;
   assign w_issue   = (r_state == ISSUE);
   assign w_k       = r_cnt[KW-1:0];

   assign mult_pixel  = w_issue ? r_pix[w_k] : '0;
   assign mult_weight = w_issue ? r_wgt[w_k] : '0;

   assign res_valid = (r_state == RESULT);
   assign res_id    = r_id;
   assign res_data  = r_acc;
   assign busy      = (r_state != IDLE);

   always_comb begin
      w_gid = '0;
      for (int r = 0; r < NUM_REQ; r++)
         if (w_grant[r])
            w_gid = IDW'(r);
   end

   // Operand mux for the granted requester; w_grant is one-hot.
   always_comb begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
         w_cap_pix[k] = '0;
         w_cap_wgt[k] = '0;
      end
      for (int r = 0; r < NUM_REQ; r++) begin
         for (int k = 0; k < NUM_INPUTS; k++) begin
            if (w_grant[r]) begin
               w_cap_pix[k] = req_pixels[(r*NUM_INPUTS+k)*PIXEL_WIDTH
                                         +: PIXEL_WIDTH];
               w_cap_wgt[k] = req_weights[(r*NUM_INPUTS+k)*WEIGHT_WIDTH
                                          +: WEIGHT_WIDTH];
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (w_take) begin
               w_state_nxt = ISSUE;
               w_cnt_nxt   = '0;
            end
         end
         ISSUE: begin
            if (r_cnt == CW'(NUM_INPUTS - 1)) begin
               w_state_nxt = DRAIN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (r_cnt == CW'(MULT_LATENCY - 1)) begin
               w_state_nxt = RESULT;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         RESULT: begin
            if (res_ready)
               w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // The tap at the top of the pipe marks a product of an issued pair.
   always_comb begin
      w_vpipe_nxt    = '0;
      w_vpipe_nxt[0] = w_issue;
      for (int i = 1; i < MULT_LATENCY; i++)
         w_vpipe_nxt[i] = r_vpipe[i-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_vpipe <= '0;
         r_acc   <= '0;
         r_id    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_vpipe <= w_vpipe_nxt;
         if (w_take) begin
            r_acc <= '0;
            r_id  <= w_gid;
         end else if (r_vpipe[MULT_LATENCY-1]) begin
            r_acc <= acc_add(r_acc, mult_product);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_INPUTS; k++) begin
            r_pix[k] <= '0;
            r_wgt[k] <= '0;
         end
      end else if (w_take) begin
         for (int k = 0; k < NUM_INPUTS; k++) begin
            r_pix[k] <= w_cap_pix[k];
            r_wgt[k] <= w_cap_wgt[k];
         end
      end
   end

endmodule
